elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_pick_next.sv | 64 ++++++
 rtl/elevator_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared widths, FSM state encoding and sweep-direction encoding for the elevator scheduler.
// Imported by the scheduler top and the SCAN target picker.
package elevator_pkg;

  localparam int FLOOR_W        = 3;
  localparam int NUM_FLOORS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_MOVE  = 2'd2,
    S_DOOR  = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_pick_next.sv
// SCAN target picker: nearest pending floor in the sweep direction, else reverse the sweep.
// Purely combinational, zero latency; no flow control.
module elevator_pick_next
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  dir,
  output logic                  found,
  output logic [FLOOR_W-1:0]    target,
  output logic                  new_dir
);

  logic               above_vld;
  logic               below_vld;
  logic [FLOOR_W-1:0] above_flr;
  logic [FLOOR_W-1:0] below_flr;

  // Descending scan leaves the closest floor above; ascending scan the closest below.
  always_comb begin
    above_vld = 1'b0;
    above_flr = '0;
    below_vld = 1'b0;
    below_flr = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(floor))) begin
        above_vld = 1'b1;
        above_flr = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(floor))) begin
        below_vld = 1'b1;
        below_flr = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    found   = above_vld | below_vld;
    target  = '0;
    new_dir = dir;
    if (dir == DIR_UP) begin
      if (above_vld) begin
        target  = above_flr;
        new_dir = DIR_UP;
      end else if (below_vld) begin
        target  = below_flr;
        new_dir = DIR_DOWN;
      end
    end else begin
      if (below_vld) begin
        target  = below_flr;
        new_dir = DIR_DOWN;
      end else if (above_vld) begin
        target  = above_flr;
        new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator request scheduler: pending bitmap, SCAN target choice, door dwell and move timeout.
// Request registered next edge; command strobe two cycles after a request from IDLE; no backpressure.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES  = 3,
  parameter int MOVE_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic [FLOOR_W-1:0]    i_req_floor,
  input  logic [FLOOR_W-1:0]    i_floor,
  output logic                  o_cmd_valid,
  output logic [FLOOR_W-1:0]    o_cmd_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up,
  output logic                  o_door_open,
  output logic                  o_fault
);

  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(DOOR_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [MW-1:0] MOVE_MAX   = MW'(MOVE_TIMEOUT);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_TIMEOUT - 1);

  logic                  rst_meta;
  logic                  rst_sync_n;
  state_t                state;
  state_t                state_nxt;
  logic [FLOOR_W-1:0]    target;
  logic [FLOOR_W-1:0]    target_nxt;
  logic                  dir;
  logic                  dir_nxt;
  logic                  fault;
  logic                  fault_nxt;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic [DW-1:0]         dwell;
  logic [DW-1:0]         dwell_nxt;
  logic [MW-1:0]         mv_cnt;
  logic [MW-1:0]         mv_nxt;
  logic                  req_ok;
  logic                  req_here;
  logic                  clr_here;
  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic                  pick_found;
  logic [FLOOR_W-1:0]    pick_target;
  logic                  pick_dir;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  elevator_pick_next #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_pick (
    .pending (pending),
    .floor   (i_floor),
    .dir     (dir),
    .found   (pick_found),
    .target  (pick_target),
    .new_dir (pick_dir)
  );

  always_comb begin
    req_ok   = i_req_valid && !fault && (int'(i_req_floor) < NUM_FLOORS);
    req_here = req_ok && (i_req_floor == i_floor);
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_mask[i] = (int'(i_floor) == i);
      set_mask[i]  = req_ok && (int'(i_req_floor) == i) && !((state == S_DOOR) && req_here);
    end
  end

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    dir_nxt     = dir;
    fault_nxt   = fault;
    dwell_nxt   = dwell;
    mv_nxt      = mv_cnt;
    clr_here    = 1'b0;
    pending_nxt = pending | set_mask;
    case (state)
      S_IDLE: begin
        if (|(pending & here_mask)) begin
          state_nxt = S_DOOR;
          clr_here  = 1'b1;
          dwell_nxt = '0;
        end else if (pick_found) begin
          state_nxt  = S_ISSUE;
          target_nxt = pick_target;
          dir_nxt    = pick_dir;
        end
      end
      S_ISSUE: begin
        state_nxt = S_MOVE;
        mv_nxt    = '0;
      end
      S_MOVE: begin
        if (i_floor == target) begin
          state_nxt = S_DOOR;
          clr_here  = 1'b1;
          dwell_nxt = '0;
        end else if (mv_cnt == MOVE_LAST) begin
          state_nxt   = S_IDLE;
          fault_nxt   = 1'b1;
          pending_nxt = '0;
        end else begin
          mv_nxt = (mv_cnt == MOVE_MAX) ? mv_cnt : mv_cnt + MW'(1);
        end
      end
      S_DOOR: begin
        // A button press at the open floor holds the doors rather than queueing a visit.
        if (req_here) begin
          dwell_nxt = '0;
        end else if (dwell == DWELL_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          dwell_nxt = (dwell == DWELL_MAX) ? dwell : dwell + DW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clr_here) begin
      pending_nxt = pending_nxt & ~here_mask;
    end
  end

  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      target  <= '0;
      dir     <= DIR_UP;
      fault   <= 1'b0;
      pending <= '0;
      dwell   <= '0;
      mv_cnt  <= '0;
    end else begin
      target  <= target_nxt;
      dir     <= dir_nxt;
      fault   <= fault_nxt;
      pending <= pending_nxt;
      dwell   <= dwell_nxt;
      mv_cnt  <= mv_nxt;
    end
  end

  assign o_cmd_valid = (state == S_ISSUE);
  assign o_door_open = (state == S_DOOR);
  assign o_cmd_floor = target;
  assign o_pending   = pending;
  assign o_dir_up    = dir;
  assign o_fault     = fault;

endmodule
